// File: rtl/alu_and64_unit.sv
// Execute-stage bitwise AND unit: one AND cell per bit. The result and its
// zero/all-ones flags are registered together, so the flags always match out.
module alu_and64_unit #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic             zero,
    output logic             all_ones
);

    logic [WIDTH-1:0] and_d;
    logic             zero_d;
    logic             all_ones_d;

    logic [WIDTH-1:0] out_q;
    logic             out_valid_q;
    logic             zero_q;
    logic             all_ones_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_and_cell
        assign and_d[i] = a[i] & b[i];
    end

    // Both flags are taken from and_d, which is the same value loaded into out_q.
    assign zero_d     = ~|and_d;
    assign all_ones_d = &and_d;

    // Valid-only handshake: in_valid high at an edge captures a and b, and
    // out_valid is high for exactly the following cycle. There is no ready.
    // While in_valid is low the data registers are not written, so unknown
    // operand values cannot propagate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            zero_q      <= 1'b1;
            all_ones_q  <= 1'b0;
        end else begin
            out_valid_q <= in_valid;
            if (in_valid) begin
                out_q      <= and_d;
                zero_q     <= zero_d;
                all_ones_q <= all_ones_d;
            end
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign zero      = zero_q;
    assign all_ones  = all_ones_q;

endmodule

// File: tb/tb_alu_and64_unit.sv
// Scoreboard bench for alu_and64_unit. The driver pushes the expected
// {out, zero, all_ones} for each accepted operand pair. A negedge monitor
// pops and compares on out_valid, checks hold otherwise, and checks the
// cleared values while in reset.
module tb_alu_and64_unit;

    localparam int W = 64;
    localparam logic [W-1:0] ONES = {W{1'b1}};
    localparam logic [W+1:0] RST_EXP = {{W{1'b0}}, 1'b1, 1'b0};

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] out;
    logic         out_valid;
    logic         zero;
    logic         all_ones;

    logic [W+1:0] exp_q[$];
    logic [W+1:0] last_exp;
    int           checks;
    int           failures;

    alu_and64_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .out       (out),
        .out_valid (out_valid),
        .zero      (zero),
        .all_ones  (all_ones)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [W+2:0] act, input logic [W+2:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s act=%h req=%h", name, act, req);
        end
    endtask

    // driver tasks
    task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                         input logic [W-1:0] e_out, input logic e_zero, input logic e_ones);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        a        = ta;
        b        = tb_v;
        exp_q.push_back({e_out, e_zero, e_ones});
    endtask

    task automatic idle(input logic [W-1:0] ta, input logic [W-1:0] tb_v);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = ta;
        b        = tb_v;
    endtask

    // monitor / scoreboard
    initial last_exp = RST_EXP;

    always @(negedge clk) begin
        if (rst) begin
            chk("in_reset", {out_valid, out, zero, all_ones}, {1'b0, RST_EXP});
            last_exp = RST_EXP;
        end else if (out_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", {1'b1, out, zero, all_ones}, {1'b0, out, zero, all_ones});
            end else begin
                logic [W+1:0] e;
                e = exp_q.pop_front();
                chk("result", {1'b0, out, zero, all_ones}, {1'b0, e});
                last_exp = e;
            end
        end else begin
            chk("hold", {1'b0, out, zero, all_ones}, {1'b0, last_exp});
        end
    end

    // stimulus
    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rv;
        int           wait_cyc;
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;

        // Reset must clear the outputs before the first clock edge.
        #2 rst = 1'b1;
        #1 chk("rst_async", {out_valid, out, zero, all_ones}, {1'b0, RST_EXP});
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        issue(64'h7FFF_FFFF_FFFF_FFFF, 64'h2, 64'h2, 1'b0, 1'b0);
        issue(64'h1, 64'h2, 64'h0, 1'b1, 1'b0);
        issue(64'h3, 64'h7, 64'h3, 1'b0, 1'b0);
        issue(ONES, ONES, ONES, 1'b0, 1'b1);
        issue(64'h8000_0000_0000_0000, ONES, 64'h8000_0000_0000_0000, 1'b0, 1'b0);
        issue(64'hA5A5_A5A5_A5A5_A5A5, 64'h5A5A_5A5A_5A5A_5A5A, 64'h0, 1'b1, 1'b0);
        issue(64'hFFFF_0000_FFFF_0000, 64'h1234_5678_9ABC_DEF0, 64'h1234_0000_9ABC_0000, 1'b0, 1'b0);

        // Outputs must hold while the operands change with in_valid low.
        idle(ONES, ONES);
        idle(64'h0, ONES);
        idle(64'hDEAD_BEEF_DEAD_BEEF, 64'hFFFF_FFFF_0000_0000);
        issue(64'h0000_0000_0000_0001, 64'h0000_0000_0000_0001, 64'h1, 1'b0, 1'b0);
        idle(ONES, ONES);
        idle(64'h5555_5555_5555_5555, 64'hAAAA_AAAA_AAAA_AAAA);

        // Reset asserted while a pair is in flight discards that pair.
        issue(64'hF0F0_F0F0_F0F0_F0F0, ONES, 64'hF0F0_F0F0_F0F0_F0F0, 1'b0, 1'b0);
        idle(64'h0, 64'h0);
        issue(64'h0F0F_0F0F_0F0F_0F0F, ONES, 64'h0F0F_0F0F_0F0F_0F0F, 1'b0, 1'b0);
        #2 rst = 1'b1;
        exp_q.delete();
        in_valid = 1'b0;
        #1 chk("rst_midstream", {out_valid, out, zero, all_ones}, {1'b0, RST_EXP});
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        issue(64'hC, 64'hA, 64'h8, 1'b0, 1'b0);
        idle(64'h0, 64'h0);

        for (int i = 0; i < 1000; i++) begin
            rv = 1'($urandom_range(0, 1));
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            case ($urandom_range(0, 7))
                0: begin ra = ONES; rb = ONES; end
                1: rb = ~ra;
                default: ;
            endcase
            if (rv) issue(ra, rb, ra & rb, (ra & rb) == '0, (ra & rb) == ONES);
            else    idle(ra, rb);
        end
        idle(64'h0, 64'h0);

        wait_cyc = 0;
        while (exp_q.size() != 0 && wait_cyc < 10) begin
            @(posedge clk);
            wait_cyc++;
        end
        chk("drain", {3'b0, 32'(exp_q.size())}, '0);
        repeat (2) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
